id_ex_skid_stage: RTL
=====================

ID_EX_SKID_STAGE -- requirements
Module: id_ex_skid_stage

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, default 32: operand and immediate width, legal values 32 or 64.
REQ-002 The block SHALL have parameter ALU_CODE_W, default 5: ALU operation code width.
REQ-003 The block SHALL have parameter REG_ADDR_W, default 5: register index width. Must be 5 while the 32-bit MIPS field layout applies.

Ports (name  direction  width  meaning):
REQ-004 The block SHALL have port clk  in  1  clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 The block SHALL have ports in_valid  in  1 and in_ready  out  1: upstream (ID) handshake.
REQ-007 The block SHALL have ports data_1_in, data_2_in  in  DATA_W: register-file read operands.
REQ-008 The block SHALL have port ins_in  in  32: decoded instruction word.
REQ-009 The block SHALL have control inputs reg_wen_in, reg_des_in, dmem_alu_in, jr_in  in  1 each, and alu_code_in  in  ALU_CODE_W.
REQ-010 The block SHALL have port flush  in  1: discard all held entries (branch or jump squash).
REQ-011 The block SHALL have ports out_valid  out  1 and out_ready  in  1: downstream (EX) handshake.
REQ-012 The block SHALL have outputs data_1_out, data_2_out, imm_out  DATA_W; rs_out, rt_out, rd_out, shamt_out  REG_ADDR_W; reg_wen_out, reg_des_out, dmem_alu_out, jr_out  1; alu_code_out  ALU_CODE_W.

Function
REQ-013 The stage SHALL be a 2-entry skid buffer: a main register drives the outputs, and a skid register holds one overflow entry.
REQ-014 Accept SHALL occur on in_valid && in_ready; transfer SHALL occur on out_valid && out_ready.
REQ-015 in_ready SHALL equal !skid_valid && !rst, and SHALL depend on no other input, so it has no combinational path from out_ready.
REQ-016 An entry SHALL be captured into main if main is empty or transferring this cycle; otherwise it SHALL be captured into skid.
REQ-017 On transfer with skid full, the skid entry SHALL move to main in the same edge.
REQ-018 The latency from accept to out_valid SHALL be 1 cycle. With out_ready held high, throughput SHALL be 1 entry per cycle.
REQ-019 Captured fields SHALL be: rs=ins[25:21], rt=ins[20:16], rd=ins[15:11], shamt=ins[10:6].
REQ-020 imm_out SHALL be ins[15:0] sign-extended to DATA_W, and SHALL be registered with the entry.
REQ-021 While out_valid=0, reg_wen_out and jr_out SHALL be forced to 0, so a bubble cannot write registers or jump; other payload outputs hold their last value.
REQ-022 Entry order SHALL be preserved; no entry is dropped or duplicated except under flush.
REQ-023 flush SHALL clear main_valid and skid_valid at the next edge, and an accept in the same cycle SHALL be discarded (flush wins). in_ready SHALL be 1 in the following cycle.
REQ-024 On simultaneous flush and transfer, the transfer SHALL count as completed downstream; the flush affects only the entries remaining.

Reset
REQ-025 On rst at a clock edge, all outputs and internal registers SHALL become 0: out_valid=0, all data, fields, imm and control outputs 0.
REQ-026 in_ready SHALL be 0 while rst is high and 1 in the first cycle after release.
REQ-027 Reset mid-operation SHALL discard both entries, with the same outcome as flush.
REQ-028 Initial-block zeroing SHALL match the reset values.

Configuration
REQ-029 Macro ID_EX_PERF_CNT_EN, when defined, SHALL add outputs stall_cnt and bubble_cnt, each 32 bits.
REQ-030 With ID_EX_PERF_CNT_EN defined, stall_cnt SHALL increment on cycles with out_valid && !out_ready.
REQ-031 With ID_EX_PERF_CNT_EN defined, bubble_cnt SHALL increment on cycles with !out_valid && !rst.
REQ-032 With ID_EX_PERF_CNT_EN defined, both counters SHALL saturate at 0xFFFFFFFF and clear on rst, not on flush.
REQ-033 Without ID_EX_PERF_CNT_EN, those ports and all counter logic SHALL be absent, with no other behavioural change.

Structure
REQ-034 Package id_ex_pkg SHALL hold: instruction field bit positions, the default ALU_CODE_W, the control-bundle struct (reg_wen, reg_des, dmem_alu, jr, alu_code) and the imm sign-extend function.
REQ-035 Sub-module pipe_skid_buf SHALL be generic over payload width and hold the valid/ready/skid logic.
REQ-036 id_ex_skid_stage SHALL pack and unpack fields around pipe_skid_buf, and SHALL own the bubble gating and the counters.

Verification
REQ-037 Stream: out_ready=1; accept ins=0x012A4020, d1=5, d2=7 -> next cycle out_valid=1, rs=9, rt=10, rd=8, shamt=0, d1_out=5, d2_out=7, imm_out=0x00004020.
REQ-038 Sign extension: ins=0x2108FFFC with DATA_W=64 -> imm_out=0xFFFFFFFFFFFFFFFC. With DATA_W=32 -> imm_out=0xFFFFFFFC.
REQ-039 Backpressure: out_ready=0, push A,B -> in_ready=0 after B, no loss. Raise out_ready -> A then B on consecutive cycles, in_ready=1 the cycle after A transfers.
REQ-040 Flush: main=A, skid=B, flush=1 with C offered -> next cycle out_valid=0, reg_wen_out=0, jr_out=0, in_ready=1. C never appears at the outputs.
REQ-041 Reset mid-stall: two entries held, rst=1 for one cycle -> all outputs 0, in_ready=0 during rst, in_ready=1 the next cycle.
REQ-042 ID_EX_PERF_CNT_EN: 3 stall cycles followed by 2 empty cycles -> stall_cnt=3, bubble_cnt=2. Counter preset near max -> holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/id_ex_pkg.sv
// rtl/id_ex_pkg.sv - instruction field layout, control bundle and immediate helper for the ID/EX stage
package id_ex_pkg;

    localparam int INS_W          = 32;
    localparam int FIELD_W        = 5;
    localparam int RS_LSB         = 21;
    localparam int RT_LSB         = 16;
    localparam int RD_LSB         = 11;
    localparam int SHAMT_LSB      = 6;
    localparam int IMM_W          = 16;
    localparam int ALU_CODE_W_DEF = 5;

    typedef struct packed {
        logic                      reg_wen;
        logic                      reg_des;
        logic                      dmem_alu;
        logic                      jr;
        logic [ALU_CODE_W_DEF-1:0] alu_code;
    } ctrl_t;

    // Full 64-bit extension; callers keep the low DATA_W bits.
    function automatic logic [63:0] sext_imm(input logic [INS_W-1:0] ins);
        return {{(64-IMM_W){ins[IMM_W-1]}}, ins[IMM_W-1:0]};
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - generic 2-entry skid buffer (main + skid register) with flush
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             accept;
    logic             xfer;

    // Registered-only ready: no combinational path from out_ready.
    assign in_ready  = !skid_valid && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign xfer      = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || xfer) begin
            // A full skid implies in_ready=0, so no accept competes with the refill.
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_data <= in_data;
                end
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/id_ex_skid_stage.sv
// rtl/id_ex_skid_stage.sv - ID/EX pipeline register on a 2-entry skid buffer
// Define ID_EX_PERF_CNT_EN to add saturating stall_cnt/bubble_cnt outputs.
module id_ex_skid_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ALU_CODE_W = ALU_CODE_W_DEF,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     data_1_in,
    input  logic [DATA_W-1:0]     data_2_in,
    input  logic [INS_W-1:0]      ins_in,
    input  logic                  reg_wen_in,
    input  logic                  reg_des_in,
    input  logic                  dmem_alu_in,
    input  logic                  jr_in,
    input  logic [ALU_CODE_W-1:0] alu_code_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     data_1_out,
    output logic [DATA_W-1:0]     data_2_out,
    output logic [DATA_W-1:0]     imm_out,
    output logic [REG_ADDR_W-1:0] rs_out,
    output logic [REG_ADDR_W-1:0] rt_out,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic [REG_ADDR_W-1:0] shamt_out,
    output logic                  reg_wen_out,
    output logic                  reg_des_out,
    output logic                  dmem_alu_out,
    output logic                  jr_out,
    output logic [ALU_CODE_W-1:0] alu_code_out
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           bubble_cnt
`endif
);

    localparam int PAY_W = 3*DATA_W + 4*REG_ADDR_W + 4 + ALU_CODE_W;

    logic [63:0]           imm_full;
    logic [DATA_W-1:0]     imm_in;
    logic [REG_ADDR_W-1:0] rs_in;
    logic [REG_ADDR_W-1:0] rt_in;
    logic [REG_ADDR_W-1:0] rd_in;
    logic [REG_ADDR_W-1:0] shamt_in;
    logic [PAY_W-1:0]      pay_in;
    logic [PAY_W-1:0]      pay_out;
    logic                  reg_wen_q;
    logic                  jr_q;

    assign imm_full = sext_imm(ins_in);
    assign imm_in   = imm_full[DATA_W-1:0];
    assign rs_in    = REG_ADDR_W'(ins_in[RS_LSB +: FIELD_W]);
    assign rt_in    = REG_ADDR_W'(ins_in[RT_LSB +: FIELD_W]);
    assign rd_in    = REG_ADDR_W'(ins_in[RD_LSB +: FIELD_W]);
    assign shamt_in = REG_ADDR_W'(ins_in[SHAMT_LSB +: FIELD_W]);

    assign pay_in = {data_1_in, data_2_in, imm_in, rs_in, rt_in, rd_in, shamt_in,
                     reg_wen_in, reg_des_in, dmem_alu_in, jr_in, alu_code_in};

    pipe_skid_buf #(
        .WIDTH(PAY_W)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (pay_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (pay_out)
    );

    assign {data_1_out, data_2_out, imm_out, rs_out, rt_out, rd_out, shamt_out,
            reg_wen_q, reg_des_out, dmem_alu_out, jr_q, alu_code_out} = pay_out;

    // A bubble must never write the register file or redirect the PC.
    assign reg_wen_out = out_valid && reg_wen_q;
    assign jr_out      = out_valid && jr_q;

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!out_valid && bubble_cnt != 32'hFFFF_FFFF) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
